demux_1x2_4b_buf: RTL and testbench

Registered 1-to-2 demultiplexer for 4-bit words: the distribution end of the 2x1 word-select path in the ALU datapath. A word arriving on a single valid/ready input is steered to one of two output channels, either by an explicit select bit or by automatic alternation. Each channel has a one-entry holding register with its own valid/ready handshake, so back-pressure on one channel never corrupts or drops data on the other.

---
 rtl/demux_1x2_4b_buf_pkg.sv | 10 +
 rtl/demux_1x2_4b_buf_if.sv | 30 +++
 rtl/demux_1x2_4b_buf_chan.sv | 43 ++++
 rtl/demux_1x2_4b_buf.sv | 57 +++++
 tb/tb_demux_1x2_4b_buf.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/demux_1x2_4b_buf_pkg.sv
// Shared constants for the registered 1-to-2 word demultiplexer.
// Channel codes double as the value of the target-select bit.
package demux_1x2_4b_buf_pkg;

   localparam int   WIDTH = 4;
   localparam int   CNT_W = 4;
   localparam logic CH0   = 1'b0;
   localparam logic CH1   = 1'b1;

endpackage

// File: rtl/demux_1x2_4b_buf_if.sv
// Input handshake, both output channels and delivery counters of the demux.
// The slave modport is the demux side; the master modport is the surrounding datapath.
interface demux_1x2_4b_buf_if;
   import demux_1x2_4b_buf_pkg::*;

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             s;
   logic             alt;
   logic [WIDTH-1:0] out0_data;
   logic             out0_valid;
   logic             out0_ready;
   logic [WIDTH-1:0] out1_data;
   logic             out1_valid;
   logic             out1_ready;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   modport slave (
      input  in_data, in_valid, s, alt, out0_ready, out1_ready,
      output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
   );

   modport master (
      output in_data, in_valid, s, alt, out0_ready, out1_ready,
      input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
   );

endinterface

// File: rtl/demux_1x2_4b_buf_chan.sv
// One output channel: single-entry holding register, full flag and delivery counter.
// Loaded word is visible the next cycle; a load in the draining cycle replaces the word without a bubble.
module demux_chan_buf
   import demux_1x2_4b_buf_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] cnt
);

   logic             full;
   logic [WIDTH-1:0] data_q;
   logic             drain;

   assign drain     = full & out_ready;
   assign out_valid = full;
   assign out_data  = data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         full   <= 1'b0;
         data_q <= '0;
         cnt    <= '0;
      end else begin
         // A load wins over a drain so a back-to-back word keeps the flag set.
         if (load) begin
            full   <= 1'b1;
            data_q <= load_data;
         end else if (drain) begin
            full <= 1'b0;
         end
         if (drain) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/demux_1x2_4b_buf.sv
// Registered 1-to-2 demux: steers each accepted word to out0/out1 by s or by alternation; one cycle latency.
// in_ready follows only the target channel, so a stalled channel never blocks or corrupts the other.
module demux_1x2_4b_buf
   import demux_1x2_4b_buf_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   demux_1x2_4b_buf_if.slave  bus
);

   logic ptr;
   logic tgt;
   logic accept;
   logic load0;
   logic load1;

   assign tgt = bus.alt ? ptr : bus.s;

   // Deliberately independent of in_valid to keep the ready path free of upstream loops.
   assign bus.in_ready = (tgt == CH1) ? (~bus.out1_valid | bus.out1_ready)
                                      : (~bus.out0_valid | bus.out0_ready);

   assign accept = bus.in_valid & bus.in_ready;
   assign load0  = accept & (tgt == CH0);
   assign load1  = accept & (tgt == CH1);

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= CH0;
      end else if (accept && bus.alt) begin
         ptr <= ~ptr;
      end
   end

   demux_chan_buf u_chan0 (
      .clk       (clk),
      .rst       (rst),
      .load      (load0),
      .load_data (bus.in_data),
      .out_data  (bus.out0_data),
      .out_valid (bus.out0_valid),
      .out_ready (bus.out0_ready),
      .cnt       (bus.cnt0)
   );

   demux_chan_buf u_chan1 (
      .clk       (clk),
      .rst       (rst),
      .load      (load1),
      .load_data (bus.in_data),
      .out_data  (bus.out1_data),
      .out_valid (bus.out1_valid),
      .out_ready (bus.out1_ready),
      .cnt       (bus.cnt1)
   );

endmodule

// File: tb/tb_demux_1x2_4b_buf.sv
// Directed bench for demux_1x2_4b_buf with hand-computed expectations.
module tb_demux_1x2_4b_buf;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   demux_1x2_4b_buf_if bus ();

   demux_1x2_4b_buf dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      bus.in_data    = '0;
      bus.in_valid   = 1'b0;
      bus.s          = 1'b0;
      bus.alt        = 1'b0;
      bus.out0_ready = 1'b1;
      bus.out1_ready = 1'b1;
      do_reset();

      chk("rst_v0",   8'(bus.out0_valid), 8'd0);
      chk("rst_v1",   8'(bus.out1_valid), 8'd0);
      chk("rst_cnt0", 8'(bus.cnt0), 8'd0);
      chk("rst_cnt1", 8'(bus.cnt1), 8'd0);

      // Explicit select to out0
      bus.in_data = 4'hA; bus.s = 1'b0; bus.alt = 1'b0; bus.in_valid = 1'b1;
      #1 chk("sel0_rdy", 8'(bus.in_ready), 8'd1);
      tick();
      bus.in_valid = 1'b0;
      chk("sel0_v0", 8'(bus.out0_valid), 8'd1);
      chk("sel0_d0", 8'(bus.out0_data), 8'hA);
      chk("sel0_v1", 8'(bus.out1_valid), 8'd0);
      tick();
      chk("sel0_cnt0", 8'(bus.cnt0), 8'd1);
      chk("sel0_drained", 8'(bus.out0_valid), 8'd0);

      // Alternation stream 1..4
      do_reset();
      bus.alt = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.in_data = 4'(k + 1); bus.in_valid = 1'b1;
         tick();
         if (k % 2 == 0) begin
            chk("alt_v0", 8'(bus.out0_valid), 8'd1);
            chk("alt_d0", 8'(bus.out0_data), 8'(k + 1));
            chk("alt_idle1", 8'(bus.out1_valid), 8'd0);
         end else begin
            chk("alt_v1", 8'(bus.out1_valid), 8'd1);
            chk("alt_d1", 8'(bus.out1_data), 8'(k + 1));
            chk("alt_idle0", 8'(bus.out0_valid), 8'd0);
         end
      end
      bus.in_valid = 1'b0;
      tick();
      chk("alt_cnt0", 8'(bus.cnt0), 8'd2);
      chk("alt_cnt1", 8'(bus.cnt1), 8'd2);
      // pointer back at channel 0
      bus.in_data = 4'h9; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("ptr0_v0", 8'(bus.out0_valid), 8'd1);
      chk("ptr0_d0", 8'(bus.out0_data), 8'h9);
      chk("ptr0_v1", 8'(bus.out1_valid), 8'd0);
      tick();
      chk("ptr0_cnt0", 8'(bus.cnt0), 8'd3);

      // Back-pressure on out1 only
      bus.alt = 1'b0; bus.s = 1'b1; bus.out1_ready = 1'b0;
      bus.in_data = 4'h5; bus.in_valid = 1'b1;
      #1 chk("bp_rdy_first", 8'(bus.in_ready), 8'd1);
      tick();
      chk("bp_v1", 8'(bus.out1_valid), 8'd1);
      bus.in_data = 4'h6;
      #1 chk("bp_rdy_blocked", 8'(bus.in_ready), 8'd0);
      tick();
      chk("bp_hold1", 8'(bus.out1_data), 8'h5);
      bus.s = 1'b0;
      #1 chk("bp_rdy_other", 8'(bus.in_ready), 8'd1);
      tick();
      bus.in_valid = 1'b0;
      chk("bp_d0", 8'(bus.out0_data), 8'h6);
      chk("bp_d1", 8'(bus.out1_data), 8'h5);
      tick();
      chk("bp_cnt0", 8'(bus.cnt0), 8'd4);

      // Drain and reload channel 0 in the same cycle
      bus.out0_ready = 1'b0;
      bus.in_data = 4'h3; bus.in_valid = 1'b1;
      tick();
      bus.out0_ready = 1'b1; bus.in_data = 4'h7;
      #1 chk("same_rdy", 8'(bus.in_ready), 8'd1);
      tick();
      bus.in_valid = 1'b0;
      chk("same_v0", 8'(bus.out0_valid), 8'd1);
      chk("same_d0", 8'(bus.out0_data), 8'h7);
      chk("same_cnt0", 8'(bus.cnt0), 8'd5);
      tick();
      chk("same_cnt0b", 8'(bus.cnt0), 8'd6);

      // Both full, neither consumer ready
      bus.out0_ready = 1'b0;
      bus.in_data = 4'h8; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.s = 1'b0;
      #1 chk("full_rdy_s0", 8'(bus.in_ready), 8'd0);
      bus.s = 1'b1;
      #1 chk("full_rdy_s1", 8'(bus.in_ready), 8'd0);
      bus.alt = 1'b1;
      #1 chk("full_rdy_alt", 8'(bus.in_ready), 8'd0);

      // Double drain plus accept
      bus.alt = 1'b0; bus.s = 1'b0;
      bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
      bus.in_data = 4'hC; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("dbl_cnt0", 8'(bus.cnt0), 8'd7);
      chk("dbl_cnt1", 8'(bus.cnt1), 8'd3);
      chk("dbl_d0", 8'(bus.out0_data), 8'hC);
      chk("dbl_v1", 8'(bus.out1_valid), 8'd0);

      // 17 words through out1: counter wraps
      do_reset();
      bus.s = 1'b1; bus.alt = 1'b0;
      for (int i = 0; i < 17; i++) begin
         bus.in_data = 4'(i); bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      chk("wrap_cnt1_16", 8'(bus.cnt1), 8'd0);
      tick();
      chk("wrap_cnt1_17", 8'(bus.cnt1), 8'd1);

      // Reset while both channels hold words and ptr = 1
      bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
      bus.alt = 1'b1; bus.in_data = 4'h1; bus.in_valid = 1'b1;
      tick();
      bus.alt = 1'b0; bus.s = 1'b1; bus.in_data = 4'h2;
      tick();
      chk("pre_rst_v0", 8'(bus.out0_valid), 8'd1);
      chk("pre_rst_v1", 8'(bus.out1_valid), 8'd1);
      rst = 1'b1; bus.in_data = 4'hF; bus.out1_ready = 1'b1;
      tick();
      rst = 1'b0; bus.in_valid = 1'b0;
      chk("mid_rst_v0", 8'(bus.out0_valid), 8'd0);
      chk("mid_rst_v1", 8'(bus.out1_valid), 8'd0);
      chk("mid_rst_cnt0", 8'(bus.cnt0), 8'd0);
      chk("mid_rst_cnt1", 8'(bus.cnt1), 8'd0);
      chk("mid_rst_d1", 8'(bus.out1_data), 8'd0);
      bus.alt = 1'b1; bus.in_data = 4'hE; bus.in_valid = 1'b1;
      bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("mid_rst_ptr_v0", 8'(bus.out0_valid), 8'd1);
      chk("mid_rst_ptr_d0", 8'(bus.out0_data), 8'hE);
      chk("mid_rst_ptr_v1", 8'(bus.out1_valid), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
